dac_serial_loader: RTL and testbench

Parametrised serial loader for AD56x8-class multi-channel DACs on the bias-generation path. It holds a per-channel code bank that host logic writes. On `start` it streams one 32-bit SPI frame per enabled channel on `Din`, framed by `SYNC_bar`, paced by `clk_en`. Over the fixed single-bias, fixed-8-channel loader it adds selectable code width, channel count, channel mask, an optional internal-reference frame, and a simultaneous-update mode.

---
 rtl/dac_serial_loader.sv | 154 +++++++++++++++
 tb/tb_dac_serial_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_serial_loader.sv
// Serial loader for AD56x8-class multi-channel DACs: streams one 32-bit SPI frame
// per enabled channel from a snapshot of a host-written code bank.
module dac_serial_loader #(
    parameter int          NUM_CH       = 8,
    parameter int          DATA_W       = 16,
    parameter logic [15:0] DEFAULT_CODE = 16'h8000,
    parameter int          GAP_TICKS    = 1,
    parameter bit          INT_REF      = 1'b0,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              mode,
    input  logic              start,
    output logic              Din,
    output logic              SYNC_bar,
    output logic              busy,
    output logic              done
);

    localparam int          GAP_W     = $clog2(GAP_TICKS) + 1;
    localparam logic [31:0] NUM_CH_U  = NUM_CH;
    localparam logic [31:0] REF_FRAME = 32'h0800_0001;

    typedef enum logic [2:0] {IDLE, REF_GAP, GAP, SHIFT, FINISH} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] bank [NUM_CH];
    logic [DATA_W-1:0] snap [NUM_CH];
    logic              snap_mode;
    logic [NUM_CH-1:0] pend, pend_next, pend_clr;
    logic [31:0]       shreg, shreg_next, frame;
    logic [4:0]        bit_cnt, bit_next;
    logic [GAP_W-1:0]  gap_cnt, gap_next;
    logic [CH_W-1:0]   sel;
    logic [3:0]        cmd;
    logic              take;

    assign take = (state == IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) bank[i] <= DEFAULT_CODE[DATA_W-1:0];
        end else if (wr_en && (32'(wr_ch) < NUM_CH_U)) begin
            bank[wr_ch] <= wr_data;
        end
    end

    // The sweep works only from this copy, so host writes during a sweep land next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) snap[i] <= DEFAULT_CODE[DATA_W-1:0];
            snap_mode <= 1'b0;
        end else if (take) begin
            snap      <= bank;
            snap_mode <= mode;
        end
    end

    // Lowest pending channel goes next, giving ascending address order.
    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) sel = CH_W'(i);
        end
    end

    always_comb begin
        pend_clr = pend & ~(NUM_CH'(1) << sel);
        if (!snap_mode)          cmd = 4'b0011;
        else if (pend_clr == '0) cmd = 4'b0010;
        else                     cmd = 4'b0000;
        frame = {4'b0000, cmd, 4'(sel), 20'(snap[sel]) << (20 - DATA_W)};
    end

    always_comb begin
        state_next = state;
        pend_next  = pend;
        shreg_next = shreg;
        bit_next   = bit_cnt;
        gap_next   = gap_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    pend_next = ch_mask;
                    gap_next  = '0;
                    if (INT_REF)           state_next = REF_GAP;
                    else if (|ch_mask)     state_next = GAP;
                    else                   state_next = FINISH;
                end
            end
            REF_GAP, GAP: begin
                if (clk_en) begin
                    if (gap_cnt == GAP_W'(GAP_TICKS - 1)) begin
                        state_next = SHIFT;
                        bit_next   = '0;
                        if (state == REF_GAP) begin
                            shreg_next = REF_FRAME;
                        end else begin
                            shreg_next = frame;
                            pend_next  = pend_clr;
                        end
                    end else begin
                        gap_next = gap_cnt + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (clk_en) begin
                    if (bit_cnt == 5'd31) begin
                        gap_next   = '0;
                        state_next = (|pend) ? GAP : FINISH;
                    end else begin
                        bit_next   = bit_cnt + 5'd1;
                        shreg_next = {shreg[30:0], 1'b0};
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so the DAC pins never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pend     <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            SYNC_bar <= 1'b1;
            Din      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            pend     <= pend_next;
            shreg    <= shreg_next;
            bit_cnt  <= bit_next;
            gap_cnt  <= gap_next;
            SYNC_bar <= (state_next != SHIFT);
            Din      <= (state_next == SHIFT) && shreg_next[31];
            busy     <= (state_next != IDLE);
            done     <= (state_next == FINISH);
        end
    end

endmodule

// File: tb/tb_dac_serial_loader.sv
// Directed bench for dac_serial_loader: a default 8-channel instance and a
// 5-channel, 12-bit, internal-reference, 2-tick-gap instance.
module tb_dac_serial_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, clk_en, en_q;
    int   en_period, en_phase;
    int   errs, checks;

    logic        wr_en_a, mode_a, start_a, din_a, sync_a, busy_a, done_a;
    logic [2:0]  wr_ch_a;
    logic [15:0] wr_data_a;
    logic [7:0]  ch_mask_a;

    logic        wr_en_b, mode_b, start_b, din_b, sync_b, busy_b, done_b;
    logic [2:0]  wr_ch_b;
    logic [11:0] wr_data_b;
    logic [4:0]  ch_mask_b;

    dac_serial_loader dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .wr_en(wr_en_a), .wr_ch(wr_ch_a),
        .wr_data(wr_data_a), .ch_mask(ch_mask_a), .mode(mode_a), .start(start_a),
        .Din(din_a), .SYNC_bar(sync_a), .busy(busy_a), .done(done_a)
    );

    dac_serial_loader #(.NUM_CH(5), .DATA_W(12), .GAP_TICKS(2), .INT_REF(1'b1)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .wr_en(wr_en_b), .wr_ch(wr_ch_b),
        .wr_data(wr_data_b), .ch_mask(ch_mask_b), .mode(mode_b), .start(start_b),
        .Din(din_b), .SYNC_bar(sync_b), .busy(busy_b), .done(done_b)
    );

    logic [31:0] fr_a, fr_b;
    logic        din_prev_a;
    int nb_a, low_a, hi_a, busy_cnt_a, done_cnt_a, din_err_a, hold_err_a;
    int nb_b, low_b, hi_b, busy_cnt_b, done_cnt_b;
    logic [31:0] frames_a[$], frames_b[$];
    int lows_a[$], gaps_a[$], bits_a[$], gaps_b[$];

    always @(posedge clk) en_q <= clk_en;

    // Frame capture on the falling edge, one bit per enabled tick, as the DAC would see it.
    always @(negedge clk) begin
        if (reset) begin
            nb_a = 0; low_a = 0; hi_a = 0;
        end else begin
            if (busy_a) busy_cnt_a++;
            if (done_a) done_cnt_a++;
            if (sync_a && din_a) din_err_a++;
            if (!en_q && din_a !== din_prev_a) hold_err_a++;
            if (!sync_a) begin
                if (low_a == 0) gaps_a.push_back(hi_a);
                low_a++;
                if (en_q) begin fr_a = {fr_a[30:0], din_a}; nb_a++; end
            end else begin
                if (low_a != 0) begin
                    frames_a.push_back(fr_a); bits_a.push_back(nb_a); lows_a.push_back(low_a);
                    low_a = 0; nb_a = 0; hi_a = 0;
                end
                if (busy_a) hi_a++;
            end
        end
        din_prev_a = din_a;
    end

    always @(negedge clk) begin
        if (reset) begin
            nb_b = 0; low_b = 0; hi_b = 0;
        end else begin
            if (busy_b) busy_cnt_b++;
            if (done_b) done_cnt_b++;
            if (!sync_b) begin
                if (low_b == 0) gaps_b.push_back(hi_b);
                low_b++;
                if (en_q) begin fr_b = {fr_b[30:0], din_b}; nb_b++; end
            end else begin
                if (low_b != 0) begin
                    frames_b.push_back(fr_b);
                    low_b = 0; nb_b = 0; hi_b = 0;
                end
                if (busy_b) hi_b++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        en_phase++;
        clk_en = (en_phase % en_period == 0);
    endtask

    task automatic clear_a();
        frames_a.delete(); lows_a.delete(); gaps_a.delete(); bits_a.delete();
        busy_cnt_a = 0; done_cnt_a = 0; din_err_a = 0; hold_err_a = 0; hi_a = 0;
    endtask

    task automatic clear_b();
        frames_b.delete(); gaps_b.delete();
        busy_cnt_b = 0; done_cnt_b = 0; hi_b = 0;
    endtask

    task automatic write_a(input logic [2:0] ch, input logic [15:0] d);
        wr_en_a = 1'b1; wr_ch_a = ch; wr_data_a = d;
        tick();
        wr_en_a = 1'b0;
    endtask

    task automatic write_b(input logic [2:0] ch, input logic [11:0] d);
        wr_en_b = 1'b1; wr_ch_b = ch; wr_data_b = d;
        tick();
        wr_en_b = 1'b0;
    endtask

    task automatic sweep_a(input logic [7:0] mask, input logic md, input int limit, output bit ok);
        clear_a();
        ch_mask_a = mask; mode_a = md; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (done_cnt_a != 0) ok = 1'b1;
        end
        repeat (3) tick();
    endtask

    task automatic sweep_b(input logic [4:0] mask, input logic md, input int limit, output bit ok);
        clear_b();
        ch_mask_b = mask; mode_b = md; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (done_cnt_b != 0) ok = 1'b1;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (sync_a !== 1'b1) begin errs++; $display("[TB] FAIL reset_sync: got %b expected 1", sync_a); end
        checks++; if (din_a !== 1'b0) begin errs++; $display("[TB] FAIL reset_din: got %b expected 0", din_a); end
        checks++; if (busy_a !== 1'b0) begin errs++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errs++; $display("[TB] FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (sync_b !== 1'b1) begin errs++; $display("[TB] FAIL reset_sync_b: got %b expected 1", sync_b); end
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_frame();
        bit ok;
        write_a(3'd0, 16'h699A);
        sweep_a(8'h01, 1'b0, 200, ok);
        checks++; if (ok !== 1'b1) begin errs++; $display("[TB] FAIL single_timeout: got %b expected 1", ok); end
        checks++; if (frames_a.size() != 1) begin errs++; $display("[TB] FAIL single_count: got %0d expected 1", frames_a.size()); end
        checks++; if (frames_a[0] !== 32'h030699A0) begin errs++; $display("[TB] FAIL single_frame: got %h expected 030699a0", frames_a[0]); end
        checks++; if (lows_a[0] != 32) begin errs++; $display("[TB] FAIL single_sync_low: got %0d expected 32", lows_a[0]); end
        checks++; if (busy_cnt_a != 34) begin errs++; $display("[TB] FAIL single_busy: got %0d expected 34", busy_cnt_a); end
        checks++; if (done_cnt_a != 1) begin errs++; $display("[TB] FAIL single_done: got %0d expected 1", done_cnt_a); end
        checks++; if (din_err_a != 0) begin errs++; $display("[TB] FAIL single_din_idle: got %0d expected 0", din_err_a); end
    endtask

    task automatic test_mode1();
        bit ok;
        write_a(3'd0, 16'h1234);
        write_a(3'd2, 16'hABCD);
        sweep_a(8'b0000_0101, 1'b1, 300, ok);
        checks++; if (ok !== 1'b1) begin errs++; $display("[TB] FAIL mode1_timeout: got %b expected 1", ok); end
        checks++; if (frames_a.size() != 2) begin errs++; $display("[TB] FAIL mode1_count: got %0d expected 2", frames_a.size()); end
        checks++; if (frames_a[0] !== 32'h00012340) begin errs++; $display("[TB] FAIL mode1_frame0: got %h expected 00012340", frames_a[0]); end
        checks++; if (frames_a[1] !== 32'h022ABCD0) begin errs++; $display("[TB] FAIL mode1_frame1: got %h expected 022abcd0", frames_a[1]); end
        checks++; if (gaps_a[1] != 1) begin errs++; $display("[TB] FAIL mode1_gap: got %0d expected 1", gaps_a[1]); end
        checks++; if (busy_cnt_a != 67) begin errs++; $display("[TB] FAIL mode1_busy: got %0d expected 67", busy_cnt_a); end
    endtask

    task automatic test_clk_en_slow();
        bit ok;
        en_period = 4;
        sweep_a(8'h01, 1'b0, 800, ok);
        en_period = 1;
        checks++; if (ok !== 1'b1) begin errs++; $display("[TB] FAIL slow_timeout: got %b expected 1", ok); end
        checks++; if (frames_a[0] !== 32'h03012340) begin errs++; $display("[TB] FAIL slow_frame: got %h expected 03012340", frames_a[0]); end
        checks++; if (bits_a[0] != 32) begin errs++; $display("[TB] FAIL slow_bits: got %0d expected 32", bits_a[0]); end
        checks++; if (lows_a[0] != 128) begin errs++; $display("[TB] FAIL slow_sync_low: got %0d expected 128", lows_a[0]); end
        checks++; if (hold_err_a != 0) begin errs++; $display("[TB] FAIL slow_hold: got %0d expected 0", hold_err_a); end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok3;
        clear_a();
        ch_mask_a = 8'hFF; mode_a = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ok1 = 1'b0;
        for (int i = 0; i < 20 && !ok1; i++) begin tick(); if (sync_a === 1'b0) ok1 = 1'b1; end
        write_a(3'd3, 16'h0000);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        ok2 = 1'b0;
        for (int i = 0; i < 200 && !ok2; i++) begin tick(); if (frames_a.size() >= 4) ok2 = 1'b1; end
        for (int i = 0; i < 20; i++) begin tick(); if (sync_a === 1'b0) break; end
        repeat (5) tick();
        checks++; if ({ok1, ok2} !== 2'b11) begin errs++; $display("[TB] FAIL b2b_timeout: got %b expected 11", {ok1, ok2}); end
        checks++; if (frames_a[0] !== 32'h03012340) begin errs++; $display("[TB] FAIL b2b_frame0: got %h expected 03012340", frames_a[0]); end
        checks++; if (frames_a[1] !== 32'h03180000) begin errs++; $display("[TB] FAIL b2b_frame1: got %h expected 03180000", frames_a[1]); end
        checks++; if (frames_a[2] !== 32'h032ABCD0) begin errs++; $display("[TB] FAIL b2b_frame2: got %h expected 032abcd0", frames_a[2]); end
        checks++; if (frames_a[3] !== 32'h03380000) begin errs++; $display("[TB] FAIL b2b_snapshot: got %h expected 03380000", frames_a[3]); end
        checks++; if (done_cnt_a != 0) begin errs++; $display("[TB] FAIL b2b_done: got %0d expected 0", done_cnt_a); end
        checks++; if (sync_a !== 1'b0) begin errs++; $display("[TB] FAIL b2b_midframe: got %b expected 0", sync_a); end
        reset = 1'b1;
        #1;
        checks++; if (sync_a !== 1'b1) begin errs++; $display("[TB] FAIL abort_sync: got %b expected 1", sync_a); end
        checks++; if (din_a !== 1'b0) begin errs++; $display("[TB] FAIL abort_din: got %b expected 0", din_a); end
        checks++; if (busy_a !== 1'b0) begin errs++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_a); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        sweep_a(8'b0000_1001, 1'b0, 300, ok3);
        checks++; if (ok3 !== 1'b1) begin errs++; $display("[TB] FAIL bank_timeout: got %b expected 1", ok3); end
        checks++; if (frames_a[0] !== 32'h03080000) begin errs++; $display("[TB] FAIL bank_ch0: got %h expected 03080000", frames_a[0]); end
        checks++; if (frames_a[1] !== 32'h03380000) begin errs++; $display("[TB] FAIL bank_ch3: got %h expected 03380000", frames_a[1]); end
    endtask

    task automatic test_empty_mask();
        bit ok;
        sweep_a(8'h00, 1'b0, 20, ok);
        checks++; if (ok !== 1'b1) begin errs++; $display("[TB] FAIL empty_timeout: got %b expected 1", ok); end
        checks++; if (busy_cnt_a != 1) begin errs++; $display("[TB] FAIL empty_busy: got %0d expected 1", busy_cnt_a); end
        checks++; if (done_cnt_a != 1) begin errs++; $display("[TB] FAIL empty_done: got %0d expected 1", done_cnt_a); end
        checks++; if (frames_a.size() != 0) begin errs++; $display("[TB] FAIL empty_frames: got %0d expected 0", frames_a.size()); end
    endtask

    task automatic test_int_ref_w12();
        bit ok;
        write_b(3'd0, 12'hABC);
        write_b(3'd5, 12'hFFF);
        write_b(3'd7, 12'hFFF);
        sweep_b(5'h01, 1'b0, 300, ok);
        checks++; if (ok !== 1'b1) begin errs++; $display("[TB] FAIL ref_timeout: got %b expected 1", ok); end
        checks++; if (frames_b.size() != 2) begin errs++; $display("[TB] FAIL ref_count: got %0d expected 2", frames_b.size()); end
        checks++; if (frames_b[0] !== 32'h08000001) begin errs++; $display("[TB] FAIL ref_frame: got %h expected 08000001", frames_b[0]); end
        checks++; if (frames_b[1] !== 32'h030ABC00) begin errs++; $display("[TB] FAIL w12_frame: got %h expected 030abc00", frames_b[1]); end
        checks++; if (gaps_b[1] != 2) begin errs++; $display("[TB] FAIL ref_gap: got %0d expected 2", gaps_b[1]); end
        checks++; if (busy_cnt_b != 69) begin errs++; $display("[TB] FAIL ref_busy: got %0d expected 69", busy_cnt_b); end
        sweep_b(5'h00, 1'b0, 100, ok);
        checks++; if (frames_b.size() != 1 || frames_b[0] !== 32'h08000001) begin errs++; $display("[TB] FAIL ref_empty: got %0d frames first %h expected 1 frame 08000001", frames_b.size(), frames_b[0]); end
        checks++; if (busy_cnt_b != 35) begin errs++; $display("[TB] FAIL ref_empty_busy: got %0d expected 35", busy_cnt_b); end
        sweep_b(5'h1F, 1'b1, 400, ok);
        checks++; if (frames_b.size() != 6) begin errs++; $display("[TB] FAIL all_count: got %0d expected 6", frames_b.size()); end
        checks++; if (frames_b[1] !== 32'h000ABC00) begin errs++; $display("[TB] FAIL all_ch0: got %h expected 000abc00", frames_b[1]); end
        checks++; if (frames_b[4] !== 32'h00300000) begin errs++; $display("[TB] FAIL all_ch3: got %h expected 00300000", frames_b[4]); end
        checks++; if (frames_b[5] !== 32'h02400000) begin errs++; $display("[TB] FAIL all_ch4: got %h expected 02400000", frames_b[5]); end
    endtask

    initial begin
        errs = 0; checks = 0; en_period = 1; en_phase = 0;
        reset = 1'b1; clk_en = 1'b1;
        wr_en_a = 1'b0; wr_ch_a = '0; wr_data_a = '0; ch_mask_a = '0; mode_a = 1'b0; start_a = 1'b0;
        wr_en_b = 1'b0; wr_ch_b = '0; wr_data_b = '0; ch_mask_b = '0; mode_b = 1'b0; start_b = 1'b0;
        clear_a();
        clear_b();
        test_reset();
        test_single_frame();
        test_mode1();
        test_clk_en_slow();
        test_back_to_back();
        test_empty_mask();
        test_int_ref_w12();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
